// File: rtl/pulse_phase_checker.sv
// pulse_phase_checker: oversampling monitor for the four-phase pulse bus with p23 overlap strobe
//   clock, clear          : system sampling clock, synchronous active-high reset
//   enable                : checker enable; low forces IDLE but keeps flags and counts
//   p1..p4, p23           : asynchronous bus pins
//   phase, phase_valid    : decoded phase (0=p1 .. 3=p4) and whether it is being tracked
//   locked, cycle_count   : LOCKED state and completed p4->p1 wraps while locked
//   seq_err, onehot_err, p23_err, stall_err, error : sticky error flags and their OR
//   err_count             : saturating count of clocks with at least one new error event
module pulse_phase_checker #(
    parameter int LOCK_COUNT = 4,
    parameter int TIMEOUT    = 64,
    parameter int CW         = 16
) (
    input  logic          clock,
    input  logic          clear,
    input  logic          enable,
    input  logic          p1,
    input  logic          p2,
    input  logic          p3,
    input  logic          p4,
    input  logic          p23,
    output logic [1:0]    phase,
    output logic          phase_valid,
    output logic          locked,
    output logic [CW-1:0] cycle_count,
    output logic          seq_err,
    output logic          onehot_err,
    output logic          p23_err,
    output logic          stall_err,
    output logic [7:0]    err_count,
    output logic          error
);
    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int SW = $clog2(TIMEOUT + 1);
    localparam logic [1:0] S_IDLE = 2'd0, S_ACQ = 2'd1, S_LOCK = 2'd2;
    // bit i of the sampled word is phase i; bit 4 is p23
    logic [4:0]    sync1, sync2;
    logic [1:0]    state;
    logic [GW-1:0] good_cnt;
    logic [SW-1:0] stall_cnt;
    logic [3:0]    hot;
    logic          zero, onehot, multi, advance, correct, timeout;
    logic          seq_ev, oh_ev, p23_ev, stall_ev, any_ev;
    logic [1:0]    new_ph;
    always_comb begin
        hot      = sync2[3:0];
        zero     = hot == 4'd0;
        onehot   = $onehot(hot);
        multi    = !zero && !onehot;
        new_ph   = {hot[3] | hot[2], hot[3] | hot[1]};
        advance  = onehot && state != S_IDLE && new_ph != phase;
        correct  = new_ph == phase + 2'd1;
        timeout  = stall_cnt == SW'(TIMEOUT - 1);
        seq_ev   = enable && state == S_LOCK && advance && !correct;
        stall_ev = enable && state == S_LOCK && !advance && timeout;
        oh_ev    = enable && multi;
        p23_ev   = enable && !multi && (sync2[4] != (hot[1] | hot[2]));
        any_ev   = seq_ev || stall_ev || oh_ev || p23_ev;
    end
    assign error = seq_err | onehot_err | p23_err | stall_err;
    always_ff @(posedge clock) begin
        if (clear) begin
            sync1       <= '0;
            sync2       <= '0;
            state       <= S_IDLE;
            phase       <= '0;
            phase_valid <= 1'b0;
            locked      <= 1'b0;
            cycle_count <= '0;
            good_cnt    <= '0;
            stall_cnt   <= '0;
            seq_err     <= 1'b0;
            onehot_err  <= 1'b0;
            p23_err     <= 1'b0;
            stall_err   <= 1'b0;
            err_count   <= '0;
        end else begin
            sync1 <= {p23, p4, p3, p2, p1};
            sync2 <= sync1;
            if (seq_ev) seq_err <= 1'b1;
            if (oh_ev) onehot_err <= 1'b1;
            if (p23_ev) p23_err <= 1'b1;
            if (stall_ev) stall_err <= 1'b1;
            if (any_ev && err_count != 8'hff) err_count <= err_count + 8'd1;
            if (!enable) begin
                state       <= S_IDLE;
                phase_valid <= 1'b0;
                locked      <= 1'b0;
                good_cnt    <= '0;
                stall_cnt   <= '0;
            end else begin
                case (state)
                    S_IDLE: if (onehot) begin
                        phase       <= new_ph;
                        phase_valid <= 1'b1;
                        good_cnt    <= '0;
                        stall_cnt   <= '0;
                        state       <= S_ACQ;
                    end
                    S_ACQ: if (advance) begin
                        phase    <= new_ph;
                        good_cnt <= correct ? good_cnt + GW'(1) : '0;
                        if (correct && good_cnt == GW'(LOCK_COUNT - 1)) begin
                            state     <= S_LOCK;
                            locked    <= 1'b1;
                            stall_cnt <= '0;
                        end
                    end
                    S_LOCK: if (advance) begin
                        phase     <= new_ph;
                        stall_cnt <= '0;
                        if (correct && phase == 2'd3) cycle_count <= cycle_count + CW'(1);
                        if (!correct) begin
                            state    <= S_ACQ;
                            locked   <= 1'b0;
                            good_cnt <= '0;
                        end
                    end else if (timeout) begin
                        state       <= S_IDLE;
                        phase_valid <= 1'b0;
                        locked      <= 1'b0;
                        stall_cnt   <= '0;
                    end else begin
                        stall_cnt <= stall_cnt + SW'(1);
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pulse_phase_checker.sv
// tb_pulse_phase_checker: directed scoreboard bench for pulse_phase_checker
module tb_pulse_phase_checker;
    logic clock = 1'b0, clear = 1'b1, enable = 1'b0;
    logic p1 = 1'b0, p2 = 1'b0, p3 = 1'b0, p4 = 1'b0, p23 = 1'b0;
    logic [1:0] phase;
    logic phase_valid, locked, seq_err, onehot_err, p23_err, stall_err, error;
    logic [15:0] cycle_count;
    logic [7:0] err_count;
    pulse_phase_checker dut (
        .clock(clock), .clear(clear), .enable(enable),
        .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p23(p23),
        .phase(phase), .phase_valid(phase_valid), .locked(locked),
        .cycle_count(cycle_count), .seq_err(seq_err), .onehot_err(onehot_err),
        .p23_err(p23_err), .stall_err(stall_err), .err_count(err_count), .error(error)
    );
    always #5 clock = ~clock;
    typedef struct packed {
        logic [1:0]  ph;
        logic        pv;
        logic        lk;
        logic [15:0] cc;
        logic [3:0]  fl;
        logic [7:0]  ec;
        logic        er;
    } obs_t;
    typedef struct {
        int    due;
        string name;
        obs_t  exp;
    } item_t;
    localparam logic [4:0] PH0 = 5'b00001, PH1 = 5'b10010, PH2 = 5'b10100, PH3 = 5'b01000;
    item_t sbq[$];
    int cyc = 0;
    int n_cmp = 0, n_bad = 0;
    obs_t act;
    assign act = {phase, phase_valid, locked, cycle_count,
                  seq_err, onehot_err, p23_err, stall_err, err_count, error};
    always @(posedge clock) cyc <= cyc + 1;
    function automatic string fmt(obs_t o);
        return $sformatf("ph=%0d pv=%0b lk=%0b cc=%0d seq/oh/p23/st=%b ec=%0d err=%0b",
                         o.ph, o.pv, o.lk, o.cc, o.fl, o.ec, o.er);
    endfunction
    always @(negedge clock) begin
        item_t it;
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            it = sbq.pop_front();
            n_cmp++;
            if (act !== it.exp) begin
                n_bad++;
                $display("FAIL %s: got {%s} want {%s}", it.name, fmt(act), fmt(it.exp));
            end
        end
    end
    function automatic logic [4:0] phv(int i);
        case (i % 4)
            0: return PH0;
            1: return PH1;
            2: return PH2;
            default: return PH3;
        endcase
    endfunction
    task automatic tick(int n);
        repeat (n) @(posedge clock);
        #1;
    endtask
    task automatic pins(logic [4:0] v, int n);
        {p23, p4, p3, p2, p1} = v;
        tick(n);
    endtask
    task automatic rot(int start, int count, int n);
        for (int k = 0; k < count; k++) pins(phv(start + k), n);
    endtask
    // lag 2: the outputs then reflect every pin sample taken up to the current edge
    task automatic chk(string nm, int lag, logic [1:0] ph, logic pv, logic lk,
                       logic [15:0] cc, logic [3:0] fl, logic [7:0] ec);
        item_t it;
        it.due  = cyc + lag;
        it.name = nm;
        it.exp  = {ph, pv, lk, cc, fl, ec, |fl};
        sbq.push_back(it);
    endtask
    initial begin
        tick(3);
        chk("reset", 1, 0, 0, 0, 0, 4'b0000, 0);
        clear = 1'b0;
        enable = 1'b1;
        rot(0, 4, 3);
        chk("pre_lock", 2, 3, 1, 0, 0, 4'b0000, 0);
        rot(0, 1, 3);
        chk("lock", 2, 0, 1, 1, 0, 4'b0000, 0);
        rot(1, 4, 3);
        chk("wrap1", 2, 0, 1, 1, 1, 4'b0000, 0);
        rot(1, 4, 3);
        chk("wrap2", 2, 0, 1, 1, 2, 4'b0000, 0);
        pins(PH2, 3);
        chk("skip", 2, 2, 1, 0, 2, 4'b1000, 1);
        rot(3, 3, 3);
        chk("relock_pre", 2, 1, 1, 0, 2, 4'b1000, 1);
        pins(PH2, 3);
        chk("relock", 2, 2, 1, 1, 2, 4'b1000, 1);
        rot(3, 2, 3);
        chk("wrap3", 2, 0, 1, 1, 3, 4'b1000, 1);
        pins(5'b10110, 1);
        chk("multi", 2, 0, 1, 1, 3, 4'b1100, 2);
        pins(PH1, 3);
        chk("after_multi", 2, 1, 1, 1, 3, 4'b1100, 2);
        pins(5'b00100, 2);
        chk("p23", 2, 2, 1, 1, 3, 4'b1110, 4);
        pins(5'b10001, 1);
        chk("seq_p23_once", 2, 0, 1, 0, 3, 4'b1110, 5);
        pins(5'b01100, 1);
        chk("multi_p3p4", 2, 0, 1, 0, 3, 4'b1110, 6);
        pins(PH0, 2);
        rot(1, 4, 3);
        chk("relock2", 2, 0, 1, 1, 3, 4'b1110, 6);
        pins(PH1, 64);
        chk("pre_stall", 2, 1, 1, 1, 3, 4'b1110, 6);
        pins(PH1, 1);
        chk("stall", 2, 1, 0, 0, 3, 4'b1111, 7);
        tick(2);
        enable = 1'b0;
        pins(5'b00011, 4);
        chk("disabled", 2, 1, 0, 0, 3, 4'b1111, 7);
        pins(5'b00000, 3);
        enable = 1'b1;
        pins(5'b00011, 300);
        chk("saturate", 2, 1, 0, 0, 3, 4'b1111, 255);
        rot(0, 5, 3);
        chk("lock_final", 2, 0, 1, 1, 3, 4'b1111, 255);
        tick(2);
        clear = 1'b1;
        chk("clear", 1, 0, 0, 0, 0, 4'b0000, 0);
        tick(1);
        clear = 1'b0;
        pins(5'b00000, 4);
        for (int k = 0; k < 20 && sbq.size() > 0; k++) @(negedge clock);
        if (sbq.size() > 0) begin
            $display("FAIL drain: %0d checks pending, required 0", sbq.size());
            n_cmp += sbq.size();
            n_bad += sbq.size();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
